// File: rtl/xmit_serial.sv
// Start/8-data/stop serializer with a valid/ready byte input, LSB first, CLKS_PER_BIT clocks per bit.
// Define XMIT_SERIAL_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module xmit_serial #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] xmit_data,
    input  logic       xmit_valid,
    output logic       xmit_ready,
    output logic       xmit_line,
    output logic       xmit_busy,
    output logic       xmit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef XMIT_SERIAL_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             done_q, done_d;
    logic             bit_end_s;
`ifdef XMIT_SERIAL_PARITY_EN
    // Parity is captured at accept time because the shift register is consumed during DATA.
    logic             parity_q, parity_d;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shift_q  <= 8'h00;
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            done_q   <= 1'b0;
`ifdef XMIT_SERIAL_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
`ifdef XMIT_SERIAL_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state, bit-period counter, shift and index update.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
`ifdef XMIT_SERIAL_PARITY_EN
        parity_d  = parity_q;
`endif
        bit_end_s = (cnt_q == CNT_LAST);
        case (state_q)
            ST_IDLE: begin
                if (xmit_valid) begin
                    shift_d  = xmit_data;
                    cnt_d    = '0;
                    idx_d    = 3'd0;
`ifdef XMIT_SERIAL_PARITY_EN
                    parity_d = even_parity(xmit_data);
`endif
                    state_d  = ST_START;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef XMIT_SERIAL_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
`ifdef XMIT_SERIAL_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = 3'd0;
            end
        endcase
    end

    // Line level decoded from registers only, so reset forces it high asynchronously.
    always_comb begin
        xmit_line = 1'b1;
        case (state_q)
            ST_IDLE:   xmit_line = 1'b1;
            ST_START:  xmit_line = 1'b0;
            ST_DATA:   xmit_line = shift_q[0];
`ifdef XMIT_SERIAL_PARITY_EN
            ST_PARITY: xmit_line = parity_q;
`endif
            ST_STOP:   xmit_line = 1'b1;
            default:   xmit_line = 1'b1;
        endcase
    end

    assign xmit_ready = (state_q == ST_IDLE);
    assign xmit_busy  = (state_q != ST_IDLE);
    assign xmit_done  = done_q;

endmodule

// File: tb/tb_xmit_serial.sv
// Scoreboard bench for xmit_serial: four instances (N=4,1,8,2) checked cycle by cycle against a frame model.
module tb_xmit_serial;

    localparam int NI = 4;
`ifdef XMIT_SERIAL_PARITY_EN
    localparam int FBITS = 11;
`else
    localparam int FBITS = 10;
`endif

    function automatic int n_of(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 8;
            default: return 2;
        endcase
    endfunction

    typedef struct packed {
        logic       line;
        logic       busy;
        logic       done;
        logic       valid;
        logic [7:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NI-1:0] valid_r;
    logic [7:0]    data_r [NI];
    wire  [NI-1:0] ready_w, line_w, busy_w, done_w;

    int   checks = 0;
    int   failures = 0;
    ent_t sb [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        xmit_serial #(.CLKS_PER_BIT(n_of(g))) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .xmit_data  (data_r[g]),
            .xmit_valid (valid_r[g]),
            .xmit_ready (ready_w[g]),
            .xmit_line  (line_w[g]),
            .xmit_busy  (busy_w[g]),
            .xmit_done  (done_w[g])
        );
    end

    task automatic push_ent(input logic l, input logic b, input logic d, input logic v, input logic [7:0] x);
        ent_t e;
        e.line = l; e.busy = b; e.done = d; e.valid = v; e.data = x;
        sb.push_back(e);
    endtask

    task automatic push_idle(input int k);
        for (int i = 0; i < k; i++) push_ent(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Expected line per cycle for one frame, then the done cycle; fv/fd/noisy drive inputs while busy.
    task automatic push_frame(input int n, input logic [7:0] b, input logic fv, input logic [7:0] fd,
                              input logic noisy, input logic dv, input logic [7:0] dd);
        logic bitv;
        for (int j = 0; j < FBITS; j++) begin
            if (j == 0)                           bitv = 1'b0;
            else if (j <= 8)                      bitv = b[j-1];
            else if (j == 9 && FBITS == 11)       bitv = ^b;
            else                                  bitv = 1'b1;
            for (int c = 0; c < n; c++) begin
                if (noisy) push_ent(bitv, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
                else       push_ent(bitv, 1'b1, 1'b0, fv, fd);
            end
        end
        push_ent(1'b1, 1'b0, 1'b1, dv, dd);
    endtask

    task automatic run_sb(input int sel, input int max_n);
        ent_t e;
        logic [3:0] obs_v, exp_v;
        for (int i = 0; i < max_n && sb.size() > 0; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            obs_v = {line_w[sel], busy_w[sel], ready_w[sel], done_w[sel]};
            exp_v = {e.line, e.busy, ~e.busy, e.done};
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL sb_cycle inst=%0d step=%0d {line,busy,ready,done} got=%b exp=%b", sel, i, obs_v, exp_v);
            end
            valid_r[sel] = e.valid;
            data_r[sel]  = e.data;
        end
    endtask

    task automatic accept(input int sel, input logic [7:0] b);
        @(negedge clk);
        checks++;
        if (ready_w[sel] !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready inst=%0d got=%b exp=1", sel, ready_w[sel]);
        end
        valid_r[sel] = 1'b1;
        data_r[sel]  = b;
    endtask

    task automatic test_reset();
        for (int g = 0; g < NI; g++) begin
            checks++;
            if ({line_w[g], busy_w[g], ready_w[g], done_w[g]} !== 4'b1010) begin
                failures++;
                $display("FAIL reset_outputs inst=%0d got=%b exp=1010", g, {line_w[g], busy_w[g], ready_w[g], done_w[g]});
            end
        end
        push_idle(100);
        run_sb(0, 100);
    endtask

    task automatic test_basic_a5();
        accept(0, 8'hA5);
        push_frame(4, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        push_idle(2);
        run_sb(0, 100);
    endtask

    task automatic test_parity_n2();
        accept(3, 8'h07);
        push_frame(2, 8'h07, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        push_idle(2);
        run_sb(3, 100);
    endtask

    task automatic test_back_to_back();
        accept(1, 8'h00);
        push_frame(1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 8'hFF);
        push_frame(1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        push_idle(3);
        run_sb(1, 100);
    endtask

    task automatic test_ignore_busy();
        accept(0, 8'h96);
        push_frame(4, 8'h96, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        push_idle(12);
        run_sb(0, 100);
    endtask

    task automatic test_reset_midframe();
        accept(2, 8'h55);
        push_frame(8, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        run_sb(2, 36);
        sb.delete();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({line_w[2], busy_w[2], ready_w[2], done_w[2]} !== 4'b1010) begin
            failures++;
            $display("FAIL midframe_reset got=%b exp=1010", {line_w[2], busy_w[2], ready_w[2], done_w[2]});
        end
        valid_r = '0;
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(5);
        run_sb(2, 5);
        accept(2, 8'h3C);
        push_frame(8, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        push_idle(2);
        run_sb(2, 200);
    endtask

    initial begin
        valid_r = '0;
        for (int g = 0; g < NI; g++) data_r[g] = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_basic_a5();
        test_parity_n2();
        test_back_to_back();
        test_ignore_busy();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
